coeff_loader: RTL and testbench
===============================

COEFF_LOADER -- requirements
Module: coeff_loader

Interface
REQ-001 SHALL have parameter N_LAYERS, default 5, number of conv layers.
REQ-002 SHALL have parameter N_KERNELS, default 64, output kernels per layer.
REQ-003 SHALL have parameter N_DEPTH, default 64, input channels per kernel.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-006 SHALL have port in_data  input  8  coefficient byte stream.
REQ-007 SHALL have port in_valid  input  1  in_data is valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts a byte; transfer when in_valid && in_ready.
REQ-009 SHALL have port w_wr_en  output  1  weight RAM write strobe.
REQ-010 SHALL have port w_wr_addr  output  clog2(N_LAYERS*N_KERNELS*N_DEPTH*9)  weight RAM address.
REQ-011 SHALL have port b_wr_en  output  1  bias RAM write strobe.
REQ-012 SHALL have port b_wr_addr  output  clog2(N_LAYERS*N_KERNELS)  bias RAM address.
REQ-013 SHALL have port wr_data  output  32  signed coefficient for either RAM.
REQ-014 SHALL have port layer_valid  output  N_LAYERS  bit L high means layer L is loaded and checksum-clean.
REQ-015 SHALL have port done  output  1  one-cycle pulse on a good frame.
REQ-016 SHALL have port err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-017 Frame format SHALL be: sync 0xA5, layer byte, N_KERNELS*N_DEPTH*9 weight words, N_KERNELS bias words, checksum byte.
REQ-018 Words SHALL be 4 bytes, little-endian.
REQ-019 Weight order SHALL be kernel, depth, ki, kj (kj fastest).
REQ-020 Weight address SHALL be ((layer*N_KERNELS+k)*N_DEPTH+d)*9+ki*3+kj; bias address SHALL be layer*N_KERNELS+k.
REQ-021 The FSM SHALL have the states HUNT, LAYER, WEIGHTS, BIASES, CHECK and REPORT.
REQ-022 HUNT SHALL discard bytes other than 0xA5 and SHALL go to LAYER on 0xA5.
REQ-023 In LAYER, an index >= N_LAYERS SHALL go to REPORT with err; otherwise it SHALL clear layer_valid[L] and go to WEIGHTS.
REQ-024 WEIGHTS SHALL go to BIASES after the last weight word; BIASES SHALL go to CHECK after the last bias word.
REQ-025 CHECK SHALL compare the received byte with the XOR of all bytes from the layer byte through the last bias byte, then go to REPORT.
REQ-026 In REPORT, a match SHALL set layer_valid[L] and pulse done; a mismatch SHALL pulse err and leave the bit clear; the next state SHALL be HUNT.
REQ-027 w_wr_en/b_wr_en SHALL pulse exactly one cycle, registered one cycle after the 4th byte of a word is accepted; addr and data SHALL be valid in the same cycle.
REQ-028 in_ready SHALL be 1 in every state except REPORT and except the reset cycle.
REQ-029 Input gaps (in_valid low) SHALL stall the byte counter with no side effects.
REQ-030 RAM writes already issued for a rejected frame SHALL NOT be undone; layer_valid is the sole integrity indicator.
REQ-031 Reloading a layer SHALL overwrite it in place; other layers' bits SHALL be unaffected.

Reset
REQ-032 rst SHALL force HUNT, clear all counters, the checksum and layer_valid, and drive in_ready, w_wr_en, b_wr_en, done and err to 0.
REQ-033 rst SHALL drive w_wr_addr, b_wr_addr and wr_data to 0.
REQ-034 rst asserted mid-frame SHALL abandon the frame with no further write strobes from the next cycle.

Structure
REQ-035 Package sr_pkg SHALL hold N_LAYERS/N_KERNELS/N_DEPTH defaults, SYNC_BYTE=0xA5, the coefficient type (signed 32) and the FSM state enum.
REQ-036 Sub-module word_assembler SHALL pack bytes into little-endian 32-bit words with a word_valid pulse and a sync clear.

Verification (benches with N_LAYERS=2, N_KERNELS=2, N_DEPTH=1: 18 weights, 2 biases)
REQ-037 Good frame: layer 1, weights 1..18, biases 100,200, correct checksum -> w_wr_addr 18..35 carry 1..18, b_wr_addr 2,3 carry 100,200, done pulse, layer_valid=2'b10.
REQ-038 Bad checksum: same frame with checksum^0x01 -> all 20 writes occur, err pulse, layer_valid[1]=0.
REQ-039 Bad layer byte 0x02 -> err pulse, no write strobes, FSM back in HUNT.
REQ-040 Leading garbage 0x00,0xFF and in_valid gaps of 3 cycles between every byte -> result identical to REQ-037.
REQ-041 rst asserted after the 10th weight word -> no further strobes; a fresh good frame then loads correctly.
REQ-042 Byte 0x80,0xFF,0xFF,0xFF -> wr_data=0xFFFFFF80 (-128).

Source files
------------

// File: rtl/sr_pkg.sv
// -----------------------------------------------------------------------------
// sr_pkg
// Shared definitions for the coefficient loader: default geometry, the frame
// sync byte, the signed coefficient type and the loader FSM state encoding.
// -----------------------------------------------------------------------------
package sr_pkg;

  // Default network geometry.
  localparam int DEF_N_LAYERS  = 5;
  localparam int DEF_N_KERNELS = 64;
  localparam int DEF_N_DEPTH   = 64;

  // First byte of every frame.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Coefficient as written to the weight and bias RAMs.
  typedef logic signed [31:0] coeff_t;

  // Frame parser states.
  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LAYER,
    ST_WEIGHTS,
    ST_BIASES,
    ST_CHECK,
    ST_REPORT
  } state_e;

endpackage

// File: rtl/word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Packs a byte stream into little-endian 32-bit words. The first byte received
// is the least significant byte. word/word_valid are presented combinationally
// in the cycle the fourth byte is offered, so the consumer can register them.
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   clr        : synchronous clear of the byte phase (realigns to byte 0)
//   byte_in    : incoming byte
//   byte_valid : byte_in is being consumed this cycle
//   word       : assembled word {byte_in, bytes 2..0}
//   word_valid : high for the cycle in which the fourth byte is consumed
// -----------------------------------------------------------------------------
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] buf_q, buf_d;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and no latch is inferred.
  always_comb begin
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    word       = {byte_in, buf_q};
    word_valid = 1'b0;
    if (clr) begin
      cnt_d = '0;
      buf_d = '0;
    end else if (byte_valid) begin
      // Shift new bytes in from the top so byte 0 ends up in bits [7:0].
      buf_d      = {byte_in, buf_q[23:8]};
      cnt_d      = cnt_q + 2'd1;
      word_valid = (cnt_q == 2'd3);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/coeff_loader.sv
// -----------------------------------------------------------------------------
// coeff_loader
// Parses framed coefficient streams and writes them into external weight and
// bias RAMs. Frame: 0xA5, layer byte, N_KERNELS*N_DEPTH*9 weight words,
// N_KERNELS bias words, XOR checksum byte (over layer byte .. last bias byte).
// Words are 4 bytes little-endian. A layer's valid bit is cleared when its
// reload starts and set only when the checksum matches; writes of a rejected
// frame are not rolled back.
//
// Ports
//   clk         : rising-edge clock
//   rst         : synchronous active-high reset
//   in_data     : coefficient byte stream
//   in_valid    : in_data valid
//   in_ready    : loader accepts a byte (transfer on in_valid && in_ready)
//   w_wr_en     : weight RAM write strobe (one cycle)
//   w_wr_addr   : weight RAM address
//   b_wr_en     : bias RAM write strobe (one cycle)
//   b_wr_addr   : bias RAM address
//   wr_data     : signed coefficient for either RAM
//   layer_valid : bit L set when layer L is loaded and checksum-clean
//   done        : one-cycle pulse on an accepted frame
//   err         : one-cycle pulse on a rejected frame
// -----------------------------------------------------------------------------
module coeff_loader
  import sr_pkg::*;
#(
  parameter int N_LAYERS  = DEF_N_LAYERS,
  parameter int N_KERNELS = DEF_N_KERNELS,
  parameter int N_DEPTH   = DEF_N_DEPTH,
  localparam int WPL = N_KERNELS * N_DEPTH * 9,
  localparam int WAW = $clog2(N_LAYERS * WPL),
  localparam int BAW = (N_LAYERS * N_KERNELS > 1) ? $clog2(N_LAYERS * N_KERNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                w_wr_en,
  output logic [WAW-1:0]      w_wr_addr,
  output logic                b_wr_en,
  output logic [BAW-1:0]      b_wr_addr,
  output logic signed [31:0]  wr_data,
  output logic [N_LAYERS-1:0] layer_valid,
  output logic                done,
  output logic                err
);

  localparam int LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam int CW = $clog2(WPL);

  state_e                state_q, state_d;
  logic [LW-1:0]         layer_q, layer_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            csum_q, csum_d;
  logic [N_LAYERS-1:0]   lv_q, lv_d;
  logic                  in_ready_q, in_ready_d;
  logic                  w_wr_en_q, w_wr_en_d;
  logic                  b_wr_en_q, b_wr_en_d;
  logic [WAW-1:0]        w_wr_addr_q, w_wr_addr_d;
  logic [BAW-1:0]        b_wr_addr_q, b_wr_addr_d;
  coeff_t                wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  in_words;
  logic [31:0]           asm_word;
  logic                  asm_valid;

  assign accept   = in_valid && in_ready_q;
  assign in_words = (state_q == ST_WEIGHTS) || (state_q == ST_BIASES);

  // Byte phase is realigned whenever the parser is outside the word payload.
  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (!in_words),
    .byte_in    (in_data),
    .byte_valid (accept && in_words),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    lv_d        = lv_q;
    w_wr_en_d   = 1'b0;
    b_wr_en_d   = 1'b0;
    w_wr_addr_d = w_wr_addr_q;
    b_wr_addr_d = b_wr_addr_q;
    wr_data_d   = wr_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_d = ST_LAYER;
          cnt_d   = '0;
          csum_d  = '0;
        end
      end

      ST_LAYER: begin
        if (accept) begin
          if (in_data >= 8'(N_LAYERS)) begin
            state_d = ST_REPORT;
            err_d   = 1'b1;
          end else begin
            layer_d        = in_data[LW-1:0];
            lv_d[layer_d]  = 1'b0;
            csum_d         = in_data;
            cnt_d          = '0;
            state_d        = ST_WEIGHTS;
          end
        end
      end

      ST_WEIGHTS: begin
        if (accept) begin
          csum_d = csum_q ^ in_data;
          if (asm_valid) begin
            // Stream order (kernel, depth, ki, kj) makes the word count the
            // offset inside the layer's block.
            w_wr_en_d   = 1'b1;
            w_wr_addr_d = WAW'(layer_q) * WAW'(WPL) + WAW'(cnt_q);
            wr_data_d   = $signed(asm_word);
            if (cnt_q == CW'(WPL - 1)) begin
              cnt_d   = '0;
              state_d = ST_BIASES;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end

      ST_BIASES: begin
        if (accept) begin
          csum_d = csum_q ^ in_data;
          if (asm_valid) begin
            b_wr_en_d   = 1'b1;
            b_wr_addr_d = BAW'(layer_q) * BAW'(N_KERNELS) + BAW'(cnt_q);
            wr_data_d   = $signed(asm_word);
            if (cnt_q == CW'(N_KERNELS - 1)) begin
              cnt_d   = '0;
              state_d = ST_CHECK;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end

      ST_CHECK: begin
        // Verdict is registered so done/err and layer_valid appear together
        // during the single REPORT cycle.
        if (accept) begin
          state_d = ST_REPORT;
          if (in_data == csum_q) begin
            done_d        = 1'b1;
            lv_d[layer_q] = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_REPORT: state_d = ST_HUNT;

      default: state_d = ST_HUNT;
    endcase

    // Registered ready mirrors the state being entered, so it is low exactly
    // while REPORT is current.
    in_ready_d = (state_d != ST_REPORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      layer_q     <= '0;
      cnt_q       <= '0;
      csum_q      <= '0;
      lv_q        <= '0;
      in_ready_q  <= 1'b0;
      w_wr_en_q   <= 1'b0;
      b_wr_en_q   <= 1'b0;
      w_wr_addr_q <= '0;
      b_wr_addr_q <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      lv_q        <= lv_d;
      in_ready_q  <= in_ready_d;
      w_wr_en_q   <= w_wr_en_d;
      b_wr_en_q   <= b_wr_en_d;
      w_wr_addr_q <= w_wr_addr_d;
      b_wr_addr_q <= b_wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign w_wr_en     = w_wr_en_q;
  assign w_wr_addr   = w_wr_addr_q;
  assign b_wr_en     = b_wr_en_q;
  assign b_wr_addr   = b_wr_addr_q;
  assign wr_data     = wr_data_q;
  assign layer_valid = lv_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_coeff_loader.sv
// -----------------------------------------------------------------------------
// tb_coeff_loader
// Scoreboard bench for coeff_loader with 2 layers, 2 kernels, depth 1.
// Stimulus pushes expected RAM writes and frame verdicts; a negedge monitor
// pops and compares whenever the DUT strobes a write or reports a verdict.
// -----------------------------------------------------------------------------
module tb_coeff_loader;

  localparam int NL  = 2;
  localparam int NK  = 2;
  localparam int ND  = 1;
  localparam int NW  = NK * ND * 9;
  localparam int WAW = $clog2(NL * NK * ND * 9);
  localparam int BAW = $clog2(NL * NK);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           w_wr_en;
  logic [WAW-1:0] w_wr_addr;
  logic           b_wr_en;
  logic [BAW-1:0] b_wr_addr;
  logic [31:0]    wr_data;
  logic [NL-1:0]  layer_valid;
  logic           done;
  logic           err;

  coeff_loader #(
    .N_LAYERS  (NL),
    .N_KERNELS (NK),
    .N_DEPTH   (ND)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .w_wr_en     (w_wr_en),
    .w_wr_addr   (w_wr_addr),
    .b_wr_en     (b_wr_en),
    .b_wr_addr   (b_wr_addr),
    .wr_data     (wr_data),
    .layer_valid (layer_valid),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_bias;
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t          wr_q[$];
  bit           ev_q[$];      // 1 = expect err, 0 = expect done
  int           checks = 0;
  int           errors = 0;
  logic [NL-1:0] lv_model = '0;
  logic [7:0]   csum_m;
  logic [31:0]  wts [NW];
  logic [31:0]  bss [NK];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every strobe and verdict against the scoreboard queues.
  always @(negedge clk) begin : monitor
    wr_t e;
    bit  is_err;
    if (w_wr_en === 1'b1 || b_wr_en === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", {62'd0, w_wr_en, b_wr_en}, 64'd0);
      end else begin
        e = wr_q.pop_front();
        check("wr_kind", {62'd0, w_wr_en, b_wr_en}, e.is_bias ? 64'd1 : 64'd2);
        if (e.is_bias) check("b_wr_addr", 64'(b_wr_addr), 64'(e.addr));
        else           check("w_wr_addr", 64'(w_wr_addr), 64'(e.addr));
        check("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
    if (done === 1'b1 || err === 1'b1) begin
      if (ev_q.size() == 0) begin
        check("unexpected_event", {62'd0, done, err}, 64'd0);
      end else begin
        is_err = ev_q.pop_front();
        check("verdict", {62'd0, done, err}, is_err ? 64'd1 : 64'd2);
        check("ready_in_report", 64'(in_ready), 64'd0);
      end
    end
  end

  // Inputs change 1 time unit after a rising edge; ready is sampled on the
  // falling edge before the edge that would transfer the byte.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int t;
    in_data  = b;
    in_valid = 1'b1;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 20) begin
      @(negedge clk);
      acc = (in_ready === 1'b1);
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    if (!acc) check("ready_timeout", 64'd0, 64'd1);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = w[8*i +: 8];
      csum_m ^= b;
      send_byte(b, gap);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((ev_q.size() != 0 || wr_q.size() != 0) && t < 60) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drained", 64'(ev_q.size() + wr_q.size()), 64'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full frame for a valid layer index, using wts/bss as the payload.
  task automatic send_frame(input int layer, input bit corrupt, input int gap, input int garbage);
    int i;
    for (int g = 0; g < garbage; g++) send_byte((g % 2 == 0) ? 8'h00 : 8'hFF, gap);
    ev_q.push_back(corrupt);
    send_byte(8'hA5, gap);
    send_byte(8'(layer), gap);
    csum_m = 8'(layer);
    i = 0;
    for (int k = 0; k < NK; k++)
      for (int d = 0; d < ND; d++)
        for (int ki = 0; ki < 3; ki++)
          for (int kj = 0; kj < 3; kj++) begin
            wr_q.push_back('{is_bias: 1'b0,
                             addr: ((layer * NK + k) * ND + d) * 9 + ki * 3 + kj,
                             data: wts[i]});
            send_word(wts[i], gap);
            i++;
          end
    for (int k = 0; k < NK; k++) begin
      wr_q.push_back('{is_bias: 1'b1, addr: layer * NK + k, data: bss[k]});
      send_word(bss[k], gap);
    end
    send_byte(csum_m ^ {7'd0, corrupt}, gap);
    lv_model[layer] = !corrupt;
    wait_idle();
    check("layer_valid", 64'(layer_valid), 64'(lv_model));
  endtask

  task automatic fill_counting();
    for (int i = 0; i < NW; i++) wts[i] = 32'(i + 1);
    bss[0] = 32'd100;
    bss[1] = 32'd200;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NW; i++) wts[i] = $urandom;
    for (int k = 0; k < NK; k++) bss[k] = $urandom;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // Reset state, sampled while rst is still asserted.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_strobes", {61'd0, w_wr_en, b_wr_en, done}, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_layer_valid", 64'(layer_valid), 64'd0);
    check("rst_addr_data", {24'd0, w_wr_addr, b_wr_addr, wr_data}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Good frame to layer 1.
    fill_counting();
    send_frame(1, 1'b0, 0, 0);
    check("good_lv", 64'(layer_valid), 64'h2);

    // Same frame, corrupted checksum: writes still happen, verdict err.
    send_frame(1, 1'b1, 0, 0);
    check("badsum_lv1", 64'(layer_valid[1]), 64'd0);

    // Out-of-range layer: err, no writes, back to hunting.
    ev_q.push_back(1'b1);
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    wait_idle();
    check("badlayer_lv", 64'(layer_valid), 64'(lv_model));
    send_byte(8'h12, 0);   // non-sync byte must be ignored in HUNT
    wait_idle();

    // Leading garbage and 3-cycle gaps between every byte.
    send_frame(1, 1'b0, 3, 2);
    check("gap_lv", 64'(layer_valid), 64'h2);

    // Little-endian sign: bytes 80 FF FF FF must write -128.
    fill_counting();
    wts[0] = 32'hFFFF_FF80;
    send_frame(0, 1'b0, 0, 0);
    check("neg_lv", 64'(layer_valid), 64'h3);

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      fill_random();
      send_frame($urandom_range(0, NL - 1), ($urandom_range(0, 3) == 0), $urandom_range(0, 2),
                 $urandom_range(0, 2));
    end

    // Reset mid-frame after the 10th weight word, part-way into the 11th.
    fill_counting();
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 10; i++) begin
      wr_q.push_back('{is_bias: 1'b0, addr: i, data: wts[i]});
      send_word(wts[i], 0);
    end
    send_byte(wts[10][7:0], 0);
    send_byte(wts[10][15:8], 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ready", 64'(in_ready), 64'd0);
    check("midrst_lv", 64'(layer_valid), 64'd0);
    #1;
    rst = 1'b0;
    lv_model = '0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check("midrst_no_pending", 64'(wr_q.size()), 64'd0);

    // Fresh frame after the abandoned one.
    fill_counting();
    send_frame(1, 1'b0, 1, 0);
    check("post_rst_lv", 64'(layer_valid), 64'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
